// File: rtl/nios2_div_pkg.sv
// Shared types, constants and sign helpers for the Nios II iterative divide cell.
package nios2_div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  function automatic logic [WIDTH_DEF-1:0] neg_cond(input logic [WIDTH_DEF-1:0] val,
                                                    input logic                 neg);
    logic [WIDTH_DEF-1:0] res;
    if (neg) begin
      res = ~val + {{(WIDTH_DEF-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH_DEF-1:0] abs_val(input logic [WIDTH_DEF-1:0] val,
                                                   input logic                 is_signed);
    return neg_cond(val, val[WIDTH_DEF-1] & is_signed);
  endfunction

endpackage

// File: rtl/nios2_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract the
// divisor when it fits.
module nios2_div_step
  import nios2_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH:0]   diff_s;

  // A set bit shifted out of rem_in means the true value exceeds any divisor,
  // so the subtract is forced and its low WIDTH bits are still exact.
  always_comb begin
    shifted_s = {rem_in[WIDTH-2:0], dvd_bit};
    diff_s    = {1'b0, shifted_s} - {1'b0, divisor};
    q_bit     = rem_in[WIDTH-1] | ~diff_s[WIDTH];
    if (q_bit) begin
      rem_out = diff_s[WIDTH-1:0];
    end else begin
      rem_out = shifted_s;
    end
  end

endmodule

// File: rtl/nios2_div_cell.sv
// Iterative radix-2 restoring divider for div/divu/rem/remu with a
// start/busy/done handshake; one quotient bit per cycle.
module nios2_div_cell
  import nios2_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = nios2_div_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             A_div_start,
  input  logic             A_div_signed,
  input  logic [WIDTH-1:0] A_div_src1,
  input  logic [WIDTH-1:0] A_div_src2,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quotient,
  output logic [WIDTH-1:0] A_div_remainder,
  output logic             A_div_by_zero
);

  if (WIDTH != 32) begin : g_width_chk
    $error("nios2_div_cell: WIDTH must be 32");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  div_state_e       state_r, state_n_s;
  logic [CNT_W-1:0] cnt_r, cnt_n_s;
  logic [WIDTH-1:0] rem_r, rem_n_s;
  logic [WIDTH-1:0] dvd_r, dvd_n_s;
  logic [WIDTH-1:0] dvsr_r, dvsr_n_s;
  logic [WIDTH-1:0] src1_r, src1_n_s;
  logic             sign1_r, sign1_n_s;
  logic             sign2_r, sign2_n_s;
  logic             zero_r, zero_n_s;
  logic             busy_r, busy_n_s;
  logic             done_r, done_n_s;
  logic [WIDTH-1:0] quo_r, quo_n_s;
  logic [WIDTH-1:0] rmd_r, rmd_n_s;
  logic             bz_r, bz_n_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_q_s;

  nios2_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .dvd_bit (dvd_r[WIDTH-1]),
    .divisor (dvsr_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // Next-state and datapath update for the IDLE/CALC/FIX sequence.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    rem_n_s   = rem_r;
    dvd_n_s   = dvd_r;
    dvsr_n_s  = dvsr_r;
    src1_n_s  = src1_r;
    sign1_n_s = sign1_r;
    sign2_n_s = sign2_r;
    zero_n_s  = zero_r;
    busy_n_s  = busy_r;
    done_n_s  = 1'b0;
    quo_n_s   = quo_r;
    rmd_n_s   = rmd_r;
    bz_n_s    = bz_r;
    case (state_r)
      IDLE: begin
        if (A_div_start) begin
          sign1_n_s = A_div_src1[WIDTH-1] & A_div_signed;
          sign2_n_s = A_div_src2[WIDTH-1] & A_div_signed;
          dvd_n_s   = abs_val(A_div_src1, A_div_signed);
          dvsr_n_s  = abs_val(A_div_src2, A_div_signed);
          zero_n_s  = (A_div_src2 == {WIDTH{1'b0}});
          src1_n_s  = A_div_src1;
          rem_n_s   = {WIDTH{1'b0}};
          cnt_n_s   = {CNT_W{1'b0}};
          busy_n_s  = 1'b1;
          state_n_s = CALC;
        end else begin
          state_n_s = IDLE;
        end
      end
      CALC: begin
        // dvd_r doubles as the quotient register: dividend bits leave at the top.
        rem_n_s = step_rem_s;
        dvd_n_s = {dvd_r[WIDTH-2:0], step_q_s};
        cnt_n_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_n_s = FIX;
        end else begin
          state_n_s = CALC;
        end
      end
      FIX: begin
        if (zero_r) begin
          quo_n_s = {WIDTH{1'b1}};
          rmd_n_s = src1_r;
          bz_n_s  = 1'b1;
        end else begin
          quo_n_s = neg_cond(dvd_r, sign1_r ^ sign2_r);
          rmd_n_s = neg_cond(rem_r, sign1_r);
          bz_n_s  = 1'b0;
        end
        done_n_s  = 1'b1;
        busy_n_s  = 1'b0;
        state_n_s = IDLE;
      end
      default: begin
        busy_n_s  = 1'b0;
        state_n_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      dvd_r   <= {WIDTH{1'b0}};
      dvsr_r  <= {WIDTH{1'b0}};
      src1_r  <= {WIDTH{1'b0}};
      sign1_r <= 1'b0;
      sign2_r <= 1'b0;
      zero_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      quo_r   <= {WIDTH{1'b0}};
      rmd_r   <= {WIDTH{1'b0}};
      bz_r    <= 1'b0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      rem_r   <= rem_n_s;
      dvd_r   <= dvd_n_s;
      dvsr_r  <= dvsr_n_s;
      src1_r  <= src1_n_s;
      sign1_r <= sign1_n_s;
      sign2_r <= sign2_n_s;
      zero_r  <= zero_n_s;
      busy_r  <= busy_n_s;
      done_r  <= done_n_s;
      quo_r   <= quo_n_s;
      rmd_r   <= rmd_n_s;
      bz_r    <= bz_n_s;
    end
  end

  assign A_div_busy      = busy_r;
  assign A_div_done      = done_r;
  assign A_div_quotient  = quo_r;
  assign A_div_remainder = rmd_r;
  assign A_div_by_zero   = bz_r;

endmodule

// File: tb/tb_nios2_div_cell.sv
// Directed self-checking bench for nios2_div_cell: arithmetic, latency,
// handshake corner cases and mid-operation reset.
module tb_nios2_div_cell;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        bz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios2_div_cell dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .A_div_start     (start),
    .A_div_signed    (sgn),
    .A_div_src1      (src1),
    .A_div_src2      (src2),
    .A_div_busy      (busy),
    .A_div_done      (done),
    .A_div_quotient  (quo),
    .A_div_remainder (rem),
    .A_div_by_zero   (bz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one start cycle; returns #1 after the sampling edge E0 with operands scrambled.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    sgn   = s;
    src1  = a;
    src2  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sgn   = ~s;
    src1  = 32'hDEADBEEF;
    src2  = 32'h0BADF00D;
  endtask

  task automatic wait_done(input int limit, output int edges, output logic seen,
                           output logic busy_ok);
    edges   = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && edges < limit) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                     input logic ebz);
    int   e;
    logic seen;
    logic bok;
    issue(s, a, b);
    wait_done(40, e, seen, bok);
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(e), 32'd33);
    check({tag, " busy_during"}, 32'(bok), 32'd1);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " quotient"}, quo, eq);
    check({tag, " remainder"}, rem, er);
    check({tag, " by_zero"}, 32'(bz), 32'(ebz));
  endtask

  initial begin
    int   e;
    int   e2;
    logic seen;
    logic bok;

    // Reset state
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst quotient", quo, 32'd0);
    check("rst remainder", rem, 32'd0);
    check("rst by_zero", 32'(bz), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);

    run("s-7/2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run("s7/-2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0);
    run("u_div0", 1'b0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    run("s_div0_min", 1'b1, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
    run("u_max/max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    run("u5/9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);

    // Start pulse at E5 of an active operation must be ignored
    issue(1'b0, 32'd1000, 32'd10);
    repeat (4) @(posedge clk);
    #1;
    sgn   = 1'b1;
    src1  = 32'd50;
    src2  = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40, e, seen, bok);
    check("ign done_seen", 32'(seen), 32'd1);
    check("ign latency", 32'(e + 5), 32'd33);
    check("ign quotient", quo, 32'd100);
    check("ign remainder", rem, 32'd0);

    // Start asserted in the done cycle is accepted
    issue(1'b0, 32'd200, 32'd9);
    wait_done(40, e2, seen, bok);
    check("b2b done_seen", 32'(seen), 32'd1);
    check("b2b gap", 32'(e2 + 1), 32'd34);
    check("b2b quotient", quo, 32'd22);
    check("b2b remainder", rem, 32'd2);

    // Asynchronous reset at E10 aborts the operation
    issue(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", quo, 32'd0);
    check("abort remainder", rem, 32'd0);
    check("abort by_zero", 32'(bz), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_done(40, e, seen, bok);
    check("abort no_done", 32'(seen), 32'd0);
    run("post_rst100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
